// File: rtl/regfile_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_unit_pkg
// Description : Shared definitions for the register-file writeback unit.
//               Holds the default data/address widths and FIFO depth, the
//               register-zero constant, and the {rd, data} entry type used
//               for queued load returns.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_writeback_unit_pkg;

  localparam int c_WIDTH  = 32;
  localparam int c_ADDR_W = 5;
  localparam int c_DEPTH  = 4;

  // x0 is hard-wired to zero; writes to it are discarded.
  localparam logic [c_ADDR_W-1:0] c_REG_ZERO = '0;

  // One queued load return at the default widths.
  typedef struct packed {
    logic [c_ADDR_W-1:0] rd;
    logic [c_WIDTH-1:0]  data;
  } wbu_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wbu_fifo
// Description : DEPTH-entry synchronous FIFO for load returns. Exposes every
//               slot's rd and a per-slot valid bit so the owner can compare
//               pending destinations without popping.
// Ports       : clk, rst (async, active-low)
//               push/push_rd/push_data : enqueue (ignored when full)
//               pop                    : dequeue head (ignored when empty)
//               head_rd/head_data      : current head entry
//               cnt/full/empty         : occupancy
//               ent_rd/ent_vld         : per-slot rd and valid flags
// Revision    : 1.0 - initial release
// ============================================================================
module wbu_fifo
  import regfile_writeback_unit_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DEPTH  = c_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_rd,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_rd,
  output logic [WIDTH-1:0]         head_data,
  output logic [CNT_W-1:0]         cnt,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH*ADDR_W-1:0]  ent_rd,
  output logic [DEPTH-1:0]         ent_vld
);

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [WIDTH-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;

  logic w_push;
  logic w_pop;

  assign full   = (r_cnt == CNT_W'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign cnt       = r_cnt;
  assign head_rd   = r_rd[r_rptr];
  assign head_data = r_data[r_rptr];
  assign ent_vld   = r_vld;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the natural
  // overflow of the increment provides the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (w_push) begin
      r_rd[r_wptr]   <= push_rd;
      r_data[r_wptr] <= push_data;
    end
  end

  // A slot cannot be pushed and popped in the same cycle: equal pointers
  // with a non-empty FIFO means full, which blocks the push.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld[i] <= 1'b0;
        end else if (w_push && (r_wptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (r_rptr == PTR_W'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
      assign ent_rd[i*ADDR_W +: ADDR_W] = r_rd[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_unit
// Description : Sole driver of the register file write port. Merges the
//               non-stallable ALU writeback stream (highest priority) with
//               the valid/ready load-return stream, buffering loads in a
//               small FIFO, and answers pending-write hazard queries.
// Ports       : clk, rst (async, active-low)
//               wb_valid/wb_rd/wb_data          : ALU result
//               ld_valid/ld_ready/ld_rd/ld_data : load return handshake
//               we_o/a_o/wd_o                   : register file WE3/A3/WD3
//               q_a1/q_a2 -> q_hit1/q_hit2      : pending-write query
//               fifo_cnt                        : load FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_unit
  import regfile_writeback_unit_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DEPTH  = c_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              we_o,
  output logic [ADDR_W-1:0] a_o,
  output logic [WIDTH-1:0]  wd_o,
  input  logic [ADDR_W-1:0] q_a1,
  input  logic [ADDR_W-1:0] q_a2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [CNT_W-1:0]  fifo_cnt
);

  localparam logic [ADDR_W-1:0] c_RZ = ADDR_W'(c_REG_ZERO);

  logic                    r_we;
  logic [ADDR_W-1:0]       r_a;
  logic [WIDTH-1:0]        r_wd;

  logic                    w_full;
  logic                    w_empty;
  logic [ADDR_W-1:0]       w_head_rd;
  logic [WIDTH-1:0]        w_head_data;
  logic [DEPTH*ADDR_W-1:0] w_ent_rd;
  logic [DEPTH-1:0]        w_ent_vld;

  logic w_wb_take;
  logic w_ld_take;
  logic w_pop;
  logic w_bypass;
  logic w_push;
  logic w_hit1;
  logic w_hit2;
  logic w_wb_pend;

  // Ready depends only on occupancy; a full FIFO refuses loads even in a
  // cycle where it pops.
  assign ld_ready  = !w_full;
  assign w_wb_take = wb_valid && (wb_rd != c_RZ);
  // Loads to x0 complete the handshake but are otherwise discarded.
  assign w_ld_take = ld_valid && ld_ready && (ld_rd != c_RZ);
  assign w_pop     = !w_wb_take && !w_empty;
  assign w_bypass  = !w_wb_take && w_empty && w_ld_take;
  assign w_push    = w_ld_take && !w_bypass;

  wbu_fifo #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_rd   (ld_rd),
    .push_data (ld_data),
    .pop       (w_pop),
    .head_rd   (w_head_rd),
    .head_data (w_head_data),
    .cnt       (fifo_cnt),
    .full      (w_full),
    .empty     (w_empty),
    .ent_rd    (w_ent_rd),
    .ent_vld   (w_ent_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we <= 1'b0;
      r_a  <= '0;
      r_wd <= '0;
    end else if (w_wb_take) begin
      r_we <= 1'b1;
      r_a  <= wb_rd;
      r_wd <= wb_data;
    end else if (w_pop) begin
      r_we <= 1'b1;
      r_a  <= w_head_rd;
      r_wd <= w_head_data;
    end else if (w_bypass) begin
      r_we <= 1'b1;
      r_a  <= ld_rd;
      r_wd <= ld_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign we_o = r_we;
  assign a_o  = r_a;
  assign wd_o = r_wd;

  // A register is pending while it sits in the FIFO or is on the write port
  // awaiting the register file edge. Only registered state is consulted.
  always_comb begin
    w_hit1    = 1'b0;
    w_hit2    = 1'b0;
    w_wb_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i*ADDR_W +: ADDR_W] == q_a1)) w_hit1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i*ADDR_W +: ADDR_W] == q_a2)) w_hit2 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i*ADDR_W +: ADDR_W] == wb_rd)) w_wb_pend = 1'b1;
    end
    if (r_we && (r_a == q_a1)) w_hit1 = 1'b1;
    if (r_we && (r_a == q_a2)) w_hit2 = 1'b1;
    if (q_a1 == c_RZ) w_hit1 = 1'b0;
    if (q_a2 == c_RZ) w_hit2 = 1'b0;
  end

  assign q_hit1 = w_hit1;
  assign q_hit2 = w_hit2;

  // The hazard unit must stall an ALU write whose destination has a queued
  // load; otherwise the older load would overwrite the newer ALU value.
  a_no_alu_over_pending_load : assert property (
    @(posedge clk) disable iff (!rst) !(w_wb_take && w_wb_pend)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback_unit
// Description : Self-checking bench for regfile_writeback_unit. A queue-based
//               reference model tracks pending loads and the expected write
//               port; directed and randomized scenarios compare against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_unit;
  import regfile_writeback_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid, ld_valid, ld_ready;
  logic [4:0]        wb_rd, ld_rd, a_o, q_a1, q_a2;
  logic [31:0]       wb_data, ld_data, wd_o;
  logic              we_o, q_hit1, q_hit2;
  logic [CNT_W-1:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  wbu_entry_t  mq[$];
  logic        exp_we;
  logic [4:0]  exp_a;
  logic [31:0] exp_wd;
  logic        last_acc;

  always #5 clk = ~clk;

  regfile_writeback_unit #(.WIDTH(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .we_o(we_o), .a_o(a_o), .wd_o(wd_o),
    .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .fifo_cnt(fifo_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic m_ready();
    return mq.size() != DEPTH;
  endfunction

  function automatic logic m_pending(input logic [4:0] a);
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (exp_we && exp_a == a) return 1'b1;
    return m_pending(a);
  endfunction

  task automatic m_reset();
    mq.delete();
    exp_we = 1'b0;
    exp_a  = '0;
    exp_wd = '0;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  // Advance the model by one clock using the current inputs, then the DUT.
  task automatic step();
    logic acc;
    wbu_entry_t e;
    acc = ld_valid && m_ready();
    last_acc = acc;
    if (wb_valid && wb_rd != 0) begin
      exp_we = 1; exp_a = wb_rd; exp_wd = wb_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = 1; exp_a = e.rd; exp_wd = e.data;
    end else if (acc && ld_rd != 0) begin
      exp_we = 1; exp_a = ld_rd; exp_wd = ld_data;
      acc = 0;
    end else begin
      exp_we = 0;
    end
    if (acc && ld_rd != 0) begin
      e.rd = ld_rd; e.data = ld_data;
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; idle(); q_a1 = 5'd9; q_a2 = 5'd0; m_reset();
    #12;
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", we_o); end
    checks++; if (a_o !== 5'd0 || wd_o !== 32'd0) begin errors++; $display("FAIL rst_addr_data: got %0h/%0h exp 0/0", a_o, wd_o); end
    checks++; if (fifo_cnt !== 3'd0 || ld_ready !== 1'b1) begin errors++; $display("FAIL rst_fifo: got cnt %0d rdy %0b exp 0/1", fifo_cnt, ld_ready); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    wb_valid = 1; wb_rd = 1; wb_data = 32'h11; ld_valid = 1; ld_rd = 20; ld_data = 32'h20;
    step();
    wb_rd = 2; ld_rd = 21; ld_data = 32'h21;
    step();
    checks++; if (fifo_cnt !== CNT_W'(mq.size())) begin errors++; $display("FAIL rst_prefill: got %0d exp %0d", fifo_cnt, mq.size()); end
    #2 rst = 0; m_reset(); idle();
    #1;
    checks++; if (we_o !== 1'b0 || fifo_cnt !== 3'd0 || ld_ready !== 1'b1) begin errors++; $display("FAIL rst_mid: got we %0b cnt %0d rdy %0b exp 0/0/1", we_o, fifo_cnt, ld_ready); end
    checks++; if (a_o !== 5'd0 || q_hit1 !== 1'b0) begin errors++; $display("FAIL rst_mid_a: got a %0h hit %0b exp 0/0", a_o, q_hit1); end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_idle_we: got %0b exp 0", we_o); end
    end
  endtask

  task automatic test_alu_single();
    idle(); wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    step();
    checks++; if (we_o !== 1'b1 || a_o !== 5'd5 || wd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write: got %0b/%0d/%0h exp 1/5/deadbeef", we_o, a_o, wd_o); end
    idle(); step();
    checks++; if (we_o !== 1'b0 || a_o !== 5'd5) begin errors++; $display("FAIL alu_idle: got we %0b a %0d exp 0/5", we_o, a_o); end
  endtask

  task automatic test_bypass();
    idle(); ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %0b exp 1", ld_ready); end
    step();
    checks++; if (we_o !== 1'b1 || a_o !== 5'd7 || wd_o !== 32'h1234 || fifo_cnt !== 3'd0) begin errors++; $display("FAIL byp_write: got %0b/%0d/%0h cnt %0d exp 1/7/1234 cnt 0", we_o, a_o, wd_o, fifo_cnt); end
    idle(); step();
  endtask

  task automatic test_contention();
    int k = 0;
    logic [4:0] order[$];
    for (int cyc = 0; cyc < 20; cyc++) begin
      wb_valid = (cyc < 5); wb_rd = 5'(cyc + 1); wb_data = $urandom;
      ld_valid = (k < 5); ld_rd = 5'(10 + k); ld_data = 32'hA000 + k;
      #1;
      checks++; if (ld_ready !== m_ready()) begin errors++; $display("FAIL cont_ready: cyc %0d got %0b exp %0b", cyc, ld_ready, m_ready()); end
      step();
      if (last_acc) k++;
      checks++; if (we_o !== exp_we || a_o !== exp_a || wd_o !== exp_wd || fifo_cnt !== CNT_W'(mq.size())) begin
        errors++; $display("FAIL cont_port: cyc %0d got %0b/%0d/%0h/%0d exp %0b/%0d/%0h/%0d", cyc, we_o, a_o, wd_o, fifo_cnt, exp_we, exp_a, exp_wd, mq.size());
      end
      if (we_o) order.push_back(a_o);
      if (cyc == 3) begin
        checks++; if (fifo_cnt !== 3'd4 || ld_ready !== 1'b0) begin errors++; $display("FAIL cont_full: got cnt %0d rdy %0b exp 4/0", fifo_cnt, ld_ready); end
      end
      if (cyc == 5) begin
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL cont_reopen: got %0b exp 1", ld_ready); end
      end
    end
    checks++; if (order.size() != 10) begin errors++; $display("FAIL cont_count: got %0d exp 10", order.size()); end
    for (int i = 0; i < 10 && i < order.size(); i++) begin
      logic [4:0] want;
      want = (i < 5) ? 5'(i + 1) : 5'(10 + i - 5);
      checks++; if (order[i] !== want) begin errors++; $display("FAIL cont_order: idx %0d got %0d exp %0d", i, order[i], want); end
    end
    idle();
  endtask

  task automatic test_x0();
    idle(); step();
    wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF;
    step();
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL x0_alu: got %0b exp 0", we_o); end
    idle(); ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b exp 1", ld_ready); end
    step();
    checks++; if (fifo_cnt !== 3'd0 || we_o !== 1'b0) begin errors++; $display("FAIL x0_load: got cnt %0d we %0b exp 0/0", fifo_cnt, we_o); end
    idle();
  endtask

  task automatic test_hazard();
    idle(); q_a1 = 9; q_a2 = 0;
    #1;
    checks++; if (q_hit1 !== 1'b0) begin errors++; $display("FAIL hz_before: got %0b exp 0", q_hit1); end
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33; ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    step();
    idle();
    #1;
    checks++; if (q_hit1 !== 1'b1 || q_hit2 !== 1'b0) begin errors++; $display("FAIL hz_queued: got %0b/%0b exp 1/0", q_hit1, q_hit2); end
    step();
    checks++; if (q_hit1 !== 1'b1 || we_o !== 1'b1 || a_o !== 5'd9) begin errors++; $display("FAIL hz_onport: got hit %0b we %0b a %0d exp 1/1/9", q_hit1, we_o, a_o); end
    step();
    checks++; if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin errors++; $display("FAIL hz_done: got %0b/%0b exp 0/0", q_hit1, q_hit2); end
  endtask

  task automatic test_wrap();
    int k = 0;
    logic [4:0] order[$];
    for (int cyc = 0; cyc < 40; cyc++) begin
      wb_valid = (cyc % 3 != 2) && (cyc < 24);
      wb_rd = 5'($urandom_range(1, 15)); wb_data = $urandom;
      ld_valid = (k < 10); ld_rd = 5'(16 + k); ld_data = $urandom;
      step();
      if (last_acc) k++;
      checks++; if (we_o !== exp_we || a_o !== exp_a || wd_o !== exp_wd || fifo_cnt !== CNT_W'(mq.size())) begin
        errors++; $display("FAIL wrap_port: cyc %0d got %0b/%0d/%0h/%0d exp %0b/%0d/%0h/%0d", cyc, we_o, a_o, wd_o, fifo_cnt, exp_we, exp_a, exp_wd, mq.size());
      end
      if (we_o && a_o >= 16) order.push_back(a_o);
    end
    checks++; if (order.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d exp 10", order.size()); end
    for (int i = 0; i < 10 && i < order.size(); i++) begin
      checks++; if (order[i] !== 5'(16 + i)) begin errors++; $display("FAIL wrap_order: idx %0d got %0d exp %0d", i, order[i], 16 + i); end
    end
    idle();
  endtask

  task automatic test_random();
    logic hold = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      wb_valid = $urandom_range(0, 1); wb_rd = 5'($urandom); wb_data = $urandom;
      for (int t = 0; t < 32 && m_pending(wb_rd); t++) wb_rd = 5'($urandom);
      if (m_pending(wb_rd)) wb_valid = 0;
      if (!hold) begin
        ld_valid = ($urandom_range(0, 3) != 0); ld_rd = 5'($urandom); ld_data = $urandom;
      end
      q_a1 = (mq.size() > 0 && $urandom_range(0, 1)) ? mq[0].rd : 5'($urandom);
      q_a2 = ($urandom_range(0, 1)) ? exp_a : 5'($urandom);
      #1;
      checks++; if (ld_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready: cyc %0d got %0b exp %0b", cyc, ld_ready, m_ready()); end
      checks++; if (q_hit1 !== m_hit(q_a1) || q_hit2 !== m_hit(q_a2)) begin
        errors++; $display("FAIL rnd_hit: cyc %0d got %0b/%0b exp %0b/%0b", cyc, q_hit1, q_hit2, m_hit(q_a1), m_hit(q_a2));
      end
      step();
      hold = ld_valid && !last_acc;
      checks++; if (we_o !== exp_we || a_o !== exp_a || wd_o !== exp_wd || fifo_cnt !== CNT_W'(mq.size())) begin
        errors++; $display("FAIL rnd_port: cyc %0d got %0b/%0d/%0h/%0d exp %0b/%0d/%0h/%0d", cyc, we_o, a_o, wd_o, fifo_cnt, exp_we, exp_a, exp_wd, mq.size());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_bypass();
    test_contention();
    test_x0();
    test_hazard();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
